mem_bus_arbiter: RTL and testbench

Arbitrates the single external memory port between two masters: the CPU (MAR/MDR path driven by the microcoded control unit) and a DMA/IO requester. Each transaction gets a fixed number of wait states. Masters use a req/ack handshake. The block sits between the datapath's memory interface and the memory/IO bus. It grants access round-robin, so neither master starves under continuous load.

---
 rtl/mem_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / DMA) round-robin arbiter for a single memory port.
// Each granted access holds the bus for WAIT_STATES+1 cycles, then pulses the owner's ack.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_wr,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            grant
);

  localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCW-1:0] WCNT_LOAD = WCW'(WAIT_STATES);
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_DMA  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_last_dma;
  logic                  r_wr;
  logic [1:0]            r_grant;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dma_rdata;
  logic                  w_pick_cpu;
  logic                  w_pick_dma;

  // On a tie the master that did not win last time gets the bus.
  assign w_pick_cpu = cpu_req & (~dma_req | r_last_dma);
  assign w_pick_dma = dma_req & (~cpu_req | ~r_last_dma);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    mem_en  = 1'b0;
    mem_wr  = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    case (r_state)
      S_IDLE:   if (cpu_req | dma_req) w_next = S_ACCESS;
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_wr = r_wr;
        if (r_wcnt == '0) w_next = S_DONE;
      end
      S_DONE: begin
        cpu_ack = (r_grant == G_CPU);
        dma_ack = (r_grant == G_DMA);
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt      <= '0;
      r_last_dma  <= 1'b1;
      r_wr        <= 1'b0;
      r_grant     <= G_NONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pick_cpu | w_pick_dma) begin
          r_mem_addr  <= w_pick_cpu ? cpu_addr  : dma_addr;
          r_mem_wdata <= w_pick_cpu ? cpu_wdata : dma_wdata;
          r_wr        <= w_pick_cpu ? cpu_wr    : dma_wr;
          r_grant     <= w_pick_cpu ? G_CPU     : G_DMA;
          r_last_dma  <= w_pick_dma;
          r_wcnt      <= WCNT_LOAD;
        end
        S_ACCESS: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - WCW'(1);
          end else if (!r_wr) begin
            if (r_grant == G_CPU) r_cpu_rdata <= mem_rdata;
            else                  r_dma_rdata <= mem_rdata;
          end
        end
        S_DONE:  r_grant <= G_NONE;
        default: r_grant <= G_NONE;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign grant     = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model that predicts each cycle from grant timestamps.
module tb_mem_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_wr = 1'b0, dma_req = 1'b0, dma_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;
  logic          cpu_ack, dma_ack, mem_en, mem_wr;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: one outstanding transaction described by its grant cycle and owner (1 CPU, 2 DMA).
  bit      m_busy;
  int      m_t0, m_owner, m_last;
  logic    m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_dma_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_t0 = 0; m_owner = 0; m_last = 2;
    m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dma_rd = '0;
  endtask

  // Advance the model across the edge that ends cycle cyc, using the inputs now applied.
  task automatic model_edge();
    if (m_busy) begin
      if (cyc == m_t0 + WS + 1 && !m_wr) begin
        if (m_owner == 1) m_cpu_rd = mem_rdata;
        else              m_dma_rd = mem_rdata;
      end
      if (cyc == m_t0 + WS + 2) m_busy = 1'b0;
    end else if (cpu_req || dma_req) begin
      if (cpu_req && dma_req) m_owner = (m_last == 2) ? 1 : 2;
      else                    m_owner = cpu_req ? 1 : 2;
      m_last  = m_owner;
      m_busy  = 1'b1;
      m_t0    = cyc;
      m_wr    = (m_owner == 1) ? cpu_wr    : dma_wr;
      m_addr  = (m_owner == 1) ? cpu_addr  : dma_addr;
      m_wdata = (m_owner == 1) ? cpu_wdata : dma_wdata;
    end
  endtask

  task automatic check_cycle();
    bit acc, ackc;
    acc  = m_busy && cyc >= m_t0 + 1 && cyc <= m_t0 + WS + 1;
    ackc = m_busy && cyc == m_t0 + WS + 2;
    chk("mem_en",    32'(mem_en),    32'(acc));
    chk("mem_wr",    32'(mem_wr),    32'(acc && m_wr));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("grant",     32'(grant),     m_busy ? 32'(m_owner) : 32'd0);
    chk("cpu_ack",   32'(cpu_ack),   32'(ackc && m_owner == 1));
    chk("dma_ack",   32'(dma_ack),   32'(ackc && m_owner == 2));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    chk("dma_rdata", 32'(dma_rdata), 32'(m_dma_rd));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic new_cpu();
    cpu_wr = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
  endtask

  task automatic new_dma();
    dma_wr = 1'($urandom); dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_en"},  32'(mem_en),    32'd0);
    chk({tag, "_mem_wr"},  32'(mem_wr),    32'd0);
    chk({tag, "_grant"},   32'(grant),     32'd0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack),   32'd0);
    chk({tag, "_dma_ack"}, 32'(dma_ack),   32'd0);
    chk({tag, "_addr"},    32'(mem_addr),  32'd0);
    chk({tag, "_wdata"},   32'(mem_wdata), 32'd0);
    chk({tag, "_cpu_rd"},  32'(cpu_rdata), 32'd0);
    chk({tag, "_dma_rd"},  32'(dma_rdata), 32'd0);
  endtask

  initial begin
    model_reset();
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(posedge clk); #1;
    check_cycle();
    rst = 1'b0;

    // Single CPU read.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h3C; mem_rdata = 8'h5A;
    tick();
    chk("cpu_rd_addr", 32'(mem_addr), 32'h3C);
    repeat (3) tick();
    chk("cpu_rd_ack", 32'(cpu_ack), 32'd1);
    chk("cpu_rd_data", 32'(cpu_rdata), 32'h5A);
    cpu_req = 1'b0;
    tick();

    // DMA write; read-data registers must not move.
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 8'h80; dma_wdata = 8'hA5; mem_rdata = 8'hEE;
    repeat (4) tick();
    chk("dma_wr_ack", 32'(dma_ack), 32'd1);
    chk("dma_wr_cpurd", 32'(cpu_rdata), 32'h5A);
    chk("dma_wr_dmard", 32'(dma_rdata), 32'h00);
    dma_req = 1'b0;
    tick();

    // Both held: grants must alternate starting with the CPU.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h11;
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 8'h22; dma_wdata = 8'h33; mem_rdata = 8'h77;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
      repeat (4) tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // CPU drops its request mid-access; DMA gets the next grant.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h44;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 8'h55; mem_rdata = 8'h9C;
    tick(); tick();
    cpu_req = 1'b0;
    tick(); tick();
    chk("drop_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("drop_cpu_rd", 32'(cpu_rdata), 32'h9C);
    tick(); tick();
    chk("drop_next_grant", 32'(grant), 32'd2);
    repeat (3) tick();
    chk("drop_dma_ack", 32'(dma_ack), 32'd1);
    dma_req = 1'b0;
    tick();

    // Reset in cycle 2 of a DMA read: no ack, then a fresh tie goes to the CPU.
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 8'h66; mem_rdata = 8'h42;
    tick(); tick();
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    dma_req = 1'b0;
    @(posedge clk); #1;
    check_cycle();
    rst = 1'b0;
    cpu_req = 1'b1; new_cpu();
    dma_req = 1'b1; new_dma();
    tick();
    chk("post_rst_grant", 32'(grant), 32'd1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      tick();
      mem_rdata = DW'($urandom);
      if (m_busy && m_owner == 1 && cyc == m_t0 + WS + 2) begin
        if ($urandom_range(1, 0) == 0) cpu_req = 1'b0; else new_cpu();
      end else if (!cpu_req) begin
        if ($urandom_range(2, 0) == 0) begin cpu_req = 1'b1; new_cpu(); end
      end else if (m_busy && m_owner == 1 && cyc <= m_t0 + WS + 1 && $urandom_range(7, 0) == 0) begin
        cpu_req = 1'b0;
      end
      if (m_busy && m_owner == 2 && cyc == m_t0 + WS + 2) begin
        if ($urandom_range(1, 0) == 0) dma_req = 1'b0; else new_dma();
      end else if (!dma_req) begin
        if ($urandom_range(2, 0) == 0) begin dma_req = 1'b1; new_dma(); end
      end else if (m_busy && m_owner == 2 && cyc <= m_t0 + WS + 1 && $urandom_range(7, 0) == 0) begin
        dma_req = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
